// File: rtl/picorv32_native_mem_responder.sv
// Responder for the PicoRV32 native memory bus: word-organised SRAM with byte strobes,
// programmable wait states, a write-only console byte sink and a sticky decode-error flag.
module picorv32_native_mem_responder #(
    parameter int unsigned MEM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] RESET_RDATA  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        console_valid,
    input  logic        console_ready,
    output logic [7:0]  console_data,
    output logic        bus_err
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CONS, S_ACK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cvalid_q, cvalid_d;
    logic [7:0]  cdata_q, cdata_d;
    logic        berr_q, berr_d;

    logic [31:0] mem [MEM_WORDS];
    logic        mem_we;
    logic [29:0] off_w;
    logic [IDX_W-1:0] idx;
    logic        sram_hit;
    logic        cons_hit;
    logic [2:0]  unused_inputs;

    // Word offset computed on addr[31:2]; BASE_ADDR is word aligned, so this equals
    // (addr - BASE_ADDR)[31:2] including the modulo-2^32 wrap below the base.
    always_comb begin
        unused_inputs = {mem_instr, mem_addr[1:0]};
        off_w    = addr_q - BASE_ADDR[31:2];
        idx      = off_w[IDX_W-1:0];
        sram_hit = ({2'b00, off_w} < MEM_WORDS);
        cons_hit = (addr_q == CONSOLE_ADDR[31:2]);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        cvalid_d = cvalid_q;
        cdata_d  = cdata_q;
        berr_d   = berr_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr[31:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cnt_d   = 8'(WAIT_STATES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (sram_hit) begin
                    if (wstrb_q == 4'b0000) rdata_d = mem[idx];
                    else                    mem_we  = 1'b1;
                    state_d = S_ACK;
                end else if (cons_hit) begin
                    if (wstrb_q != 4'b0000) begin
                        cvalid_d = 1'b1;
                        cdata_d  = wdata_q[7:0];
                        state_d  = S_CONS;
                    end else begin
                        rdata_d = '0;
                        state_d = S_ACK;
                    end
                end else begin
                    rdata_d = '0;
                    berr_d  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_CONS: begin
                if (cvalid_q && console_ready) begin
                    cvalid_d = 1'b0;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= RESET_RDATA;
            cvalid_q <= 1'b0;
            cdata_q  <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            cvalid_q <= cvalid_d;
            cdata_q  <= cdata_d;
            berr_q   <= berr_d;
        end
    end

    // SRAM is not reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        mem_ready     = (state_q == S_ACK);
        mem_rdata     = rdata_q;
        console_valid = cvalid_q;
        console_data  = cdata_q;
        bus_err       = berr_q;
    end

endmodule

// File: tb/tb_picorv32_native_mem_responder.sv
// Bench for picorv32_native_mem_responder: a zero-wait and a three-wait instance driven
// through a core-like bus task, expected responses held in a scoreboard queue.
module tb_picorv32_native_mem_responder;

    logic        clk = 1'b0;
    logic        reset, mv0, mv3, mi, cons_rdy;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mwstrb;
    logic        rdy0, rdy3, cv0, cv3, be0, be3;
    logic [31:0] rd0, rd3;
    logic [7:0]  cd0, cd3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {logic [31:0] rd; int lat;} exp_t;
    exp_t sb[$];
    logic [31:0] m3 [16];

    always #5 clk = ~clk;

    picorv32_native_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(mv0), .mem_instr(mi), .mem_ready(rdy0),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_wstrb(mwstrb), .mem_rdata(rd0),
        .console_valid(cv0), .console_ready(cons_rdy), .console_data(cd0), .bus_err(be0));

    picorv32_native_mem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_0100), .WAIT_STATES(3),
        .RESET_RDATA(32'h5A5A_5A5A)) dut3 (
        .clk(clk), .reset(reset), .mem_valid(mv3), .mem_instr(mi), .mem_ready(rdy3),
        .mem_addr(maddr), .mem_wdata(mwdata), .mem_wstrb(mwstrb), .mem_rdata(rd3),
        .console_valid(cv3), .console_ready(cons_rdy), .console_data(cd3), .bus_err(be3));

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // One core transaction; request fields are scrambled after accept, lat counts cycles to mem_ready.
    task automatic xfer(input int sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd, output time t_acc);
        @(negedge clk);
        maddr = a; mwdata = d; mwstrb = s;
        if (sel == 0) mv0 = 1'b1; else mv3 = 1'b1;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        maddr = $urandom; mwdata = $urandom; mwstrb = 4'($urandom); mi = 1'($urandom);
        lat = 1;
        while (!((sel == 0) ? rdy0 : rdy3) && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        rd = (sel == 0) ? rd0 : rd3;
        mv0 = 1'b0; mv3 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; mv0 = 1'b0; mv3 = 1'b0; mi = 1'b0; cons_rdy = 1'b0;
        maddr = '0; mwdata = '0; mwstrb = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rdy0, rd0, cv0, cd0, be0} !== {1'b0, 32'h0, 1'b0, 8'h0, 1'b0}) begin
            n_bad++; $display("FAIL reset_dut0: got %h expected %h", {rdy0, rd0, cv0, cd0, be0}, 43'h0);
        end
        n_cmp++;
        if ({rdy3, rd3, cv3, cd3, be3} !== {1'b0, 32'h5A5A_5A5A, 1'b0, 8'h0, 1'b0}) begin
            n_bad++; $display("FAIL reset_dut3: got %h expected %h", {rdy3, rd3, cv3, cd3, be3},
                              {1'b0, 32'h5A5A_5A5A, 1'b0, 8'h0, 1'b0});
        end
    endtask

    task automatic test_write_read;
        int lat; logic [31:0] rd; time t; exp_t e;
        sb.push_back('{32'h0, 2});
        xfer(0, 32'h10, 32'hA5A5_1234, 4'hF, lat, rd, t);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin n_bad++; $display("FAIL t1_write_lat: got %0d expected %0d", lat, e.lat); end
        sb.push_back('{32'hA5A5_1234, 2});
        xfer(0, 32'h10, 32'h0, 4'h0, lat, rd, t);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin n_bad++; $display("FAIL t1_read_lat: got %0d expected %0d", lat, e.lat); end
        n_cmp++;
        if (rd !== e.rd) begin n_bad++; $display("FAIL t1_read_data: got %h expected %h", rd, e.rd); end
    endtask

    task automatic test_strobe;
        logic [31:0] a_t [5] = '{32'h10, 32'h12, 32'h14, 32'h14, 32'h17};
        logic [31:0] d_t [5] = '{32'hFF99_8877, 32'h0, 32'h1122_3344, 32'h0000_BEEF, 32'h0};
        logic [3:0]  s_t [5] = '{4'b1000, 4'b0000, 4'b1111, 4'b0011, 4'b0000};
        logic [31:0] r_t [5] = '{32'h0, 32'hFFA5_1234, 32'h0, 32'h0, 32'h1122_BEEF};
        int lat; logic [31:0] rd; time t; exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{r_t[i], 2});
            xfer(0, a_t[i], d_t[i], s_t[i], lat, rd, t);
            e = sb.pop_front();
            n_cmp++;
            if (lat !== e.lat) begin n_bad++; $display("FAIL t2_lat[%0d]: got %0d expected %0d", i, lat, e.lat); end
            if (s_t[i] == 4'b0000) begin
                n_cmp++;
                if (rd !== e.rd) begin n_bad++; $display("FAIL t2_data[%0d]: got %h expected %h", i, rd, e.rd); end
            end
        end
    endtask

    task automatic test_wait_states;
        int lat; logic [31:0] rd; time t; exp_t e; logic stable;
        xfer(1, 32'h100, 32'hCAFE_F00D, 4'hF, lat, rd, t);
        m3[0] = 32'hCAFE_F00D;
        sb.push_back('{32'hCAFE_F00D, 5});
        xfer(1, 32'h100, 32'h0, 4'h0, lat, rd, t);
        e = sb.pop_front();
        n_cmp++;
        if (lat !== e.lat) begin n_bad++; $display("FAIL t3_read_lat: got %0d expected %0d", lat, e.lat); end
        n_cmp++;
        if (rd !== e.rd) begin n_bad++; $display("FAIL t3_read_data: got %h expected %h", rd, e.rd); end
        @(negedge clk);
        n_cmp++;
        if (rdy3 !== 1'b0) begin n_bad++; $display("FAIL t3_ready_pulse: got %b expected 0", rdy3); end
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rd3 !== 32'hCAFE_F00D) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin n_bad++; $display("FAIL t3_rdata_hold: got %h expected %h", rd3, 32'hCAFE_F00D); end
        xfer(1, 32'h104, 32'h1234_5678, 4'hF, lat, rd, t);
        m3[1] = 32'h1234_5678;
        n_cmp++;
        if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL t3_write_keeps_rdata: got %h expected %h", rd, 32'hCAFE_F00D); end
    endtask

    task automatic test_back_to_back;
        int wl [4] = '{2, 5, 9, 15};
        int lat; logic [31:0] rd, d; logic [3:0] s; time t, t_prev; exp_t e;
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                d = $urandom;
                s = (k == 0) ? 4'hF : (k == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
                if (s != 4'h0) m3[wl[i]] = merge((k == 0) ? 32'h0 : m3[wl[i]], d, s);
                sb.push_back('{m3[wl[i]], 5});
                xfer(1, 32'h100 + 32'(4 * wl[i]), d, s, lat, rd, t);
                e = sb.pop_front();
                n_cmp++;
                if (lat !== e.lat) begin n_bad++; $display("FAIL b2b_lat[%0d.%0d]: got %0d expected %0d", i, k, lat, e.lat); end
                if (t_prev != 0) begin
                    n_cmp++;
                    if (t - t_prev !== 60) begin n_bad++; $display("FAIL b2b_interval[%0d.%0d]: got %0t expected 60", i, k, t - t_prev); end
                end
                t_prev = t;
                if (k == 2) begin
                    n_cmp++;
                    if (rd !== e.rd) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, e.rd); end
                end
            end
        end
    endtask

    task automatic test_console;
        int n, lat; logic ok; logic [31:0] rd; time t;
        @(negedge clk);
        maddr = 32'h1000_0000; mwdata = 32'h1234_5641; mwstrb = 4'h1; mv0 = 1'b1; cons_rdy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) begin maddr = $urandom; mwdata = $urandom; end
        end while (!cv0 && n < 20);
        n_cmp++;
        if (cv0 !== 1'b1 || cd0 !== 8'h41) begin n_bad++; $display("FAIL t4_console_start: got v=%b d=%h expected v=1 d=41", cv0, cd0); end
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cv0 !== 1'b1 || cd0 !== 8'h41 || rdy0 !== 1'b0) ok = 1'b0;
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL t4_console_stall: got v=%b d=%h rdy=%b expected v=1 d=41 rdy=0", cv0, cd0, rdy0); end
        cons_rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rdy0, cv0} !== 2'b10) begin n_bad++; $display("FAIL t4_console_ack: got rdy,v=%b expected 10", {rdy0, cv0}); end
        mv0 = 1'b0; cons_rdy = 1'b0;
        xfer(0, 32'h1000_0002, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if ({lat, rd, be0} !== {32'd2, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL t4_console_read: got lat=%0d rd=%h err=%b expected lat=2 rd=0 err=0", lat, rd, be0);
        end
    endtask

    task automatic test_bus_err;
        int lat; logic [31:0] rd; time t;
        xfer(0, 32'h0FFC, 32'h600D_F00D, 4'hF, lat, rd, t);
        xfer(0, 32'h1000, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if ({lat, rd, be0} !== {32'd2, 32'h0, 1'b1}) begin
            n_bad++; $display("FAIL t5_oob_dut0: got lat=%0d rd=%h err=%b expected lat=2 rd=0 err=1", lat, rd, be0);
        end
        xfer(0, 32'h0FFC, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if ({rd, be0} !== {32'h600D_F00D, 1'b1}) begin
            n_bad++; $display("FAIL t5_sticky_dut0: got rd=%h err=%b expected rd=600df00d err=1", rd, be0);
        end
        n_cmp++;
        if (be3 !== 1'b0) begin n_bad++; $display("FAIL t5_dut3_clean: got %b expected 0", be3); end
        xfer(1, 32'h00FC, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if ({lat, rd, be3} !== {32'd5, 32'h0, 1'b1}) begin
            n_bad++; $display("FAIL t5_wrap_dut3: got lat=%0d rd=%h err=%b expected lat=5 rd=0 err=1", lat, rd, be3);
        end
        xfer(1, 32'h013C, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if ({rd, be3} !== {m3[15], 1'b1}) begin
            n_bad++; $display("FAIL t5_last_word_dut3: got rd=%h err=%b expected rd=%h err=1", rd, be3, m3[15]);
        end
        xfer(1, 32'h0140, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if ({rd, be3} !== {32'h0, 1'b1}) begin
            n_bad++; $display("FAIL t5_past_end_dut3: got rd=%h err=%b expected rd=0 err=1", rd, be3);
        end
    endtask

    task automatic test_reset_abort;
        int lat; logic [31:0] rd; time t; logic rdy_seen;
        @(negedge clk);
        maddr = 32'h104; mwdata = 32'h0BAD_0BAD; mwstrb = 4'hF; mv3 = 1'b1;
        rdy_seen = 1'b0;
        repeat (3) begin @(negedge clk); rdy_seen |= rdy3; end
        reset = 1'b1;
        @(negedge clk); rdy_seen |= rdy3;
        mv3 = 1'b0;
        @(negedge clk); rdy_seen |= rdy3;
        reset = 1'b0;
        n_cmp++;
        if ({rdy3, rd3, cv3, cd3, be3} !== {1'b0, 32'h5A5A_5A5A, 1'b0, 8'h0, 1'b0}) begin
            n_bad++; $display("FAIL t6_reset_vals_dut3: got %h expected %h", {rdy3, rd3, cv3, cd3, be3},
                              {1'b0, 32'h5A5A_5A5A, 1'b0, 8'h0, 1'b0});
        end
        @(negedge clk);
        maddr = 32'h10; mwdata = 32'hDEAD_BEEF; mwstrb = 4'hF; mv0 = 1'b1;
        @(negedge clk); rdy_seen |= rdy0;
        reset = 1'b1;
        @(negedge clk); rdy_seen |= rdy0;
        mv0 = 1'b0;
        @(negedge clk); rdy_seen |= rdy0;
        reset = 1'b0;
        n_cmp++;
        if ({rdy0, rd0, cv0, cd0, be0} !== {1'b0, 32'h0, 1'b0, 8'h0, 1'b0}) begin
            n_bad++; $display("FAIL t6_reset_vals_dut0: got %h expected %h", {rdy0, rd0, cv0, cd0, be0}, 43'h0);
        end
        repeat (3) begin @(negedge clk); rdy_seen |= rdy0 | rdy3; end
        n_cmp++;
        if (rdy_seen !== 1'b0) begin n_bad++; $display("FAIL t6_no_ready: got %b expected 0", rdy_seen); end
        xfer(0, 32'h10, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if (rd !== 32'hFFA5_1234) begin n_bad++; $display("FAIL t6_readback_dut0: got %h expected %h", rd, 32'hFFA5_1234); end
        xfer(1, 32'h104, 32'h0, 4'h0, lat, rd, t);
        n_cmp++;
        if (rd !== m3[1]) begin n_bad++; $display("FAIL t6_readback_dut3: got %h expected %h", rd, m3[1]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_wait_states();
        test_back_to_back();
        test_console();
        test_bus_err();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
